// File: rtl/smem_hsi_pkg.sv
// Shared types and helpers for the SMEM row writer on the HSI bus.
package smem_hsi_pkg;

    // Number of HSI words needed to carry one full SMEM row.
    function automatic int ENTRIES_OF(input int dw, input int segments, input int hsi_w);
        return (dw * segments) / hsi_w;
    endfunction

    // Load side: command word first, then the row's data entries.
    typedef enum logic [1:0] {
        L_IDLE,
        L_CMD,
        L_DATA
    } load_state_t;

    // Output side: issuing words, or counting out the inter-row idle gap.
    typedef enum logic {
        O_SEND,
        O_GAP
    } out_state_t;

endpackage

// File: rtl/smem_hsi_word_fifo.sv
// Show-ahead word FIFO between the load FSM and the HSI output stage.
// The head entry is visible on rd_word whenever empty=0.
module smem_hsi_word_fifo #(
    parameter type word_t = logic [33:0],
    parameter int  DEPTH  = 16
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  flush,
    input  logic  wr_en,
    input  word_t wr_word,
    input  logic  rd_en,
    output word_t rd_word,
    output logic  full,
    output logic  empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    word_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // An extra wrap bit on each pointer separates full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_word = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush and reset both drop every stored word.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write.
    // NOTE: the array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

endmodule

// File: rtl/smem_row_writer_hsi.sv
// SMEM row writer: captures a row on start, serialises it as one command word plus
// ENTRIES data words onto the HSI bus, then idles for a programmable number of hsi_ce ticks.
module smem_row_writer_hsi
    import smem_hsi_pkg::*;
#(
    parameter int DW         = 512,
    parameter int SEGMENTS   = 4,
    parameter int HSI_W      = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_W      = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DW*SEGMENTS-1:0] row_data,
    input  logic [31:0]            row_index,
    input  logic                   start,
    output logic                   ready,
    output logic                   done,
    input  logic                   abort,
    input  logic [GAP_W-1:0]       idle_gap,
    input  logic                   hsi_ce,
    input  logic                   enable,
    output logic [HSI_W-1:0]       hsi_data,
    output logic                   hsi_cmd,
    output logic                   hsi_valid,
    output logic [31:0]            rows_written
);

    localparam int               ENTRIES  = ENTRIES_OF(DW, SEGMENTS, HSI_W);
    localparam int               IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;

    typedef struct packed {
        logic [HSI_W-1:0] data;
        logic             cmd;
        logic             last;
    } hsi_word_t;

    // Capture buffer (first stage of the double buffer).
    logic                   cap_full;
    logic [DW*SEGMENTS-1:0] cap_row;
    logic [31:0]            cap_index;

    // Working copy owned by the load FSM (second stage).
    logic [ENTRIES-1:0][HSI_W-1:0] work_ent;
    logic [31:0]                   work_index;
    logic [IDX_W-1:0]              idx;

    load_state_t load_state, load_next;
    out_state_t  out_state, out_next;
    logic        take;
    logic        fifo_wr;
    hsi_word_t   wr_word;
    hsi_word_t   rd_word;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic [GAP_W-1:0] gap, gap_next;
    logic        row_done;

    assign ready = !cap_full && !abort;
    assign done  = !cap_full && (load_state == L_IDLE) && fifo_empty &&
                   (out_state == O_SEND) && !hsi_valid;

    // Capture buffer: holds one accepted row until the load FSM takes it.
    always_ff @(posedge clk) begin
        if (!resetn || abort) begin
            cap_full <= 1'b0;
        end else if (start && ready) begin
            cap_full  <= 1'b1;
            cap_row   <= row_data;
            cap_index <= row_index;
        end else if (take) begin
            cap_full <= 1'b0;
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_state <= L_IDLE;
        end else begin
            load_state <= load_next;
        end
    end

    // Load FSM: take a row from capture, then write command and data words while the FIFO has room.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        load_next = load_state;
        take      = 1'b0;
        fifo_wr   = 1'b0;
        wr_word   = '0;
        case (load_state)
            L_IDLE: begin
                if (cap_full) begin
                    take      = 1'b1;
                    load_next = L_CMD;
                end
            end
            L_CMD: begin
                wr_word.data = HSI_W'(work_index);
                wr_word.cmd  = 1'b1;
                fifo_wr      = !fifo_full;
                if (!fifo_full) begin
                    load_next = L_DATA;
                end
            end
            L_DATA: begin
                wr_word.data = work_ent[idx];
                wr_word.last = (idx == IDX_LAST);
                fifo_wr      = !fifo_full;
                if (!fifo_full && (idx == IDX_LAST)) begin
                    load_next = L_IDLE;
                end
            end
            default: load_next = L_IDLE;
        endcase
        if (abort) begin
            load_next = L_IDLE;
            take      = 1'b0;
            fifo_wr   = 1'b0;
        end
    end

    // Working row copy and entry index for the load FSM.
    always_ff @(posedge clk) begin
        if (take) begin
            work_ent   <= cap_row;
            work_index <= cap_index;
        end
        if (!resetn || (load_state != L_DATA)) begin
            idx <= '0;
        end else if (fifo_wr) begin
            idx <= idx + IDX_ONE;
        end
    end

    smem_hsi_word_fifo #(
        .word_t (hsi_word_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (abort),
        .wr_en   (fifo_wr),
        .wr_word (wr_word),
        .rd_en   (pop),
        .rd_word (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pop = (out_state == O_SEND) && !fifo_empty && hsi_ce && enable && !abort;

    // Output FSM: pop words on hsi_ce, then count out the idle gap after each row's last word.
    always_comb begin
        out_next = out_state;
        gap_next = gap;
        row_done = 1'b0;
        case (out_state)
            O_SEND: begin
                if (pop && rd_word.last) begin
                    if (idle_gap == '0) begin
                        row_done = 1'b1;
                    end else begin
                        gap_next = idle_gap;
                        out_next = O_GAP;
                    end
                end
            end
            O_GAP: begin
                if (hsi_ce) begin
                    gap_next = gap - GAP_ONE;
                    if (gap == GAP_ONE) begin
                        row_done = 1'b1;
                        out_next = O_SEND;
                    end
                end
            end
            default: out_next = O_SEND;
        endcase
        if (abort) begin
            out_next = O_SEND;
            gap_next = '0;
            row_done = 1'b0;
        end
    end

    // Output registers, gap counter and completed-row counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_state    <= O_SEND;
            gap          <= '0;
            rows_written <= '0;
            hsi_valid    <= 1'b0;
            hsi_data     <= '0;
            hsi_cmd      <= 1'b0;
        end else begin
            out_state <= out_next;
            gap       <= gap_next;
            hsi_valid <= pop;
            if (row_done) begin
                rows_written <= rows_written + 32'd1;
            end
            if (pop) begin
                hsi_data <= rd_word.data;
                hsi_cmd  <= rd_word.cmd;
            end
        end
    end

endmodule

// File: tb/tb_smem_row_writer_hsi.sv
// Scoreboard bench for smem_row_writer_hsi: expected HSI words are queued when a row is
// issued and a monitor compares them against every hsi_valid beat.
module tb_smem_row_writer_hsi;

    localparam int DW         = 64;
    localparam int SEGMENTS   = 2;
    localparam int HSI_W      = 32;
    localparam int ENTRIES    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_W      = 8;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [DW*SEGMENTS-1:0] row_data;
    logic [31:0]            row_index;
    logic                   start;
    logic                   ready;
    logic                   done;
    logic                   abort;
    logic [GAP_W-1:0]       idle_gap;
    logic                   hsi_ce;
    logic                   enable;
    logic [HSI_W-1:0]       hsi_data;
    logic                   hsi_cmd;
    logic                   hsi_valid;
    logic [31:0]            rows_written;

    always #5 clk = ~clk;

    smem_row_writer_hsi #(
        .DW         (DW),
        .SEGMENTS   (SEGMENTS),
        .HSI_W      (HSI_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_W      (GAP_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .row_data     (row_data),
        .row_index    (row_index),
        .start        (start),
        .ready        (ready),
        .done         (done),
        .abort        (abort),
        .idle_gap     (idle_gap),
        .hsi_ce       (hsi_ce),
        .enable       (enable),
        .hsi_data     (hsi_data),
        .hsi_cmd      (hsi_cmd),
        .hsi_valid    (hsi_valid),
        .rows_written (rows_written)
    );

    typedef struct {
        logic        cmd;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   words_seen = 0;
    int   rows_model = 0;
    int   ce_mode    = 0;   // 0: every clk, 1: every ce_period clks, 2: random
    int   ce_period  = 1;
    logic en_ctl     = 1'b1;
    logic rand_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a row becomes its index word followed by HSI_W-bit slices, LSBs first.
    task automatic push_row(input logic [127:0] row, input logic [31:0] idx);
        exp_q.push_back('{cmd: 1'b1, data: idx, last: 1'b0});
        for (int e = 0; e < ENTRIES; e++) begin
            exp_q.push_back('{cmd: 1'b0, data: row[e*HSI_W +: HSI_W], last: (e == ENTRIES - 1)});
        end
        rows_model++;
    endtask

    // Monitor: every issued word must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hsi_valid === 1'b1) begin
                check("sb_word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_word", {hsi_cmd, hsi_data}, {e.cmd, e.data});
                end
                words_seen++;
            end
        end
    end

    // Pacing generator for hsi_ce / enable, applied after the bench's own input updates.
    initial begin
        int cyc;
        cyc    = 0;
        hsi_ce = 1'b0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (ce_mode)
                0:       hsi_ce = 1'b1;
                1:       hsi_ce = ((cyc % ce_period) == 0);
                default: hsi_ce = (($urandom % 3) != 0);
            endcase
            enable = rand_en ? (($urandom % 6) != 0) : en_ctl;
        end
    end

    task automatic send_row(input logic [127:0] row, input logic [31:0] idx, input logic [7:0] gap);
        int k;
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check("send_ready_seen", ready, 1);
        row_data  = row;
        row_index = idx;
        idle_gap  = gap;
        start     = 1'b1;
        push_row(row, idx);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ready_low_after_start", ready, 0);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_words(input int target);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (words_seen >= target) break;
        end
        check("words_reached", words_seen >= target, 1);
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (hsi_valid) cnt++;
        end
    endtask

    task automatic check_idle_state();
        check("rows_written", rows_written, rows_model);
        check("sb_drained", exp_q.size(), 0);
    endtask

    function automatic logic [127:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int          cnt, vfirst, base, lost, rows_before, prev_rows, pos5;
        int          vpos[$];
        logic [127:0] row_a;

        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        row_data  = '0;
        row_index = '0;
        idle_gap  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 1);
        check("rst_valid", hsi_valid, 0);
        check("rst_data", hsi_data, 0);
        check("rst_cmd", hsi_cmd, 0);
        check("rst_rows", rows_written, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Case 1: single row, gap 3, full rate.
        ce_mode = 0;
        en_ctl  = 1'b1;
        row_a   = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        send_row(row_a, 32'd5, 8'd3);
        vfirst = -1;
        cnt    = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (hsi_valid) begin
                cnt++;
                if (vfirst < 0) vfirst = n;
            end
            if (n == 10) begin
                check("c1_rows_in_gap", rows_written, 0);
                check("c1_done_in_gap", done, 0);
            end
            if (n == 11) begin
                check("c1_rows_after_gap", rows_written, 1);
                check("c1_done_after_gap", done, 1);
            end
        end
        check("c1_latency", vfirst - 1, 3);
        check("c1_word_count", cnt, 5);
        wait_done(50);
        check_idle_state();

        // Case 2: back-to-back rows, gap 2.
        send_row(rand_row(), $urandom, 8'd2);
        send_row(rand_row(), $urandom, 8'd2);
        vpos.delete();
        for (int n = 0; n < 60 && vpos.size() < 10; n++) begin
            @(negedge clk);
            if (hsi_valid) vpos.push_back(n);
        end
        check("c2_word_count", vpos.size(), 10);
        if (vpos.size() == 10) begin
            check("c2_row0_contiguous", vpos[4] - vpos[0], 4);
            check("c2_idle_between_rows", vpos[5] - vpos[4] - 1, 2);
            check("c2_row1_contiguous", vpos[9] - vpos[5], 4);
        end
        wait_done(50);
        check_idle_state();

        // Case 3: slow hsi_ce and an enable stall mid-row.
        ce_mode   = 1;
        ce_period = 4;
        base      = words_seen;
        send_row(rand_row(), $urandom, 8'd1);
        send_row(rand_row(), $urandom, 8'd1);
        wait_words(base + 3);
        en_ctl = 1'b0;
        count_valid(20, cnt);
        check("c3_no_valid_while_disabled", cnt, 0);
        en_ctl = 1'b1;
        wait_done(400);
        check_idle_state();

        // Case 4: abort mid-row, then an intact row.
        ce_mode = 0;
        base    = words_seen;
        send_row(rand_row(), $urandom, 8'd1);
        wait_words(base + 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        lost  = 0;
        foreach (exp_q[i]) if (exp_q[i].last) lost++;
        rows_model -= lost;
        exp_q.delete();
        @(negedge clk);
        check("c4_valid_after_abort", hsi_valid, 0);
        @(negedge clk);
        check("c4_done_after_abort", done, 1);
        check("c4_ready_after_abort", ready, 1);
        check("c4_rows_unchanged", rows_written, rows_model);
        send_row(rand_row(), $urandom, 8'd1);
        wait_done(100);
        check_idle_state();

        // Case 5a: abort together with start.
        row_data  = rand_row();
        row_index = $urandom;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        count_valid(20, cnt);
        check("c5_abort_start_no_valid", cnt, 0);
        check("c5_abort_start_done", done, 1);
        check("c5_abort_start_ready", ready, 1);

        // Case 5b: start while ready=0 (output stalled, FIFO full, capture occupied).
        en_ctl = 1'b0;
        send_row(rand_row(), $urandom, 8'd1);
        send_row(rand_row(), $urandom, 8'd1);
        repeat (10) @(posedge clk);
        #1;
        check("c5_ready_low_when_stalled", ready, 0);
        row_data  = rand_row();
        row_index = $urandom;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count_valid(20, cnt);
        check("c5_no_valid_while_stalled", cnt, 0);
        en_ctl = 1'b1;
        wait_done(200);
        check_idle_state();

        // Case 6: idle_gap=0, hsi_ce every 2nd clk.
        ce_mode     = 1;
        ce_period   = 2;
        rows_before = rows_model;
        send_row(rand_row(), $urandom, 8'd0);
        send_row(rand_row(), $urandom, 8'd0);
        cnt       = 0;
        pos5      = 0;
        prev_rows = rows_written;
        for (int n = 0; n < 80 && cnt < 6; n++) begin
            @(negedge clk);
            if (hsi_valid) begin
                cnt++;
                if (cnt == 5) begin
                    check("c6_rows_before_last_pop", prev_rows, rows_before);
                    check("c6_rows_at_last_pop", rows_written, rows_before + 1);
                    pos5 = n;
                end
                if (cnt == 6) begin
                    check("c6_next_cmd_spacing", n - pos5, 2);
                    check("c6_next_is_cmd", hsi_cmd, 1);
                end
            end
            prev_rows = rows_written;
        end
        check("c6_words_seen", cnt, 6);
        wait_done(200);
        check_idle_state();

        // Randomised traffic: random pacing, enable and gaps.
        ce_mode = 2;
        rand_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            send_row(rand_row(), $urandom, 8'($urandom_range(0, 3)));
        end
        wait_done(3000);
        rand_en = 1'b0;
        ce_mode = 0;
        check_idle_state();

        // Reset mid-row: behaves as abort and also clears rows_written.
        base = words_seen;
        send_row(rand_row(), $urandom, 8'd1);
        wait_words(base + 2);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.delete();
        rows_model = 0;
        @(negedge clk);
        check("rst_mid_valid", hsi_valid, 0);
        check("rst_mid_rows", rows_written, 0);
        check("rst_mid_done", done, 1);
        check("rst_mid_ready", ready, 1);
        send_row(rand_row(), $urandom, 8'd2);
        wait_done(100);
        check_idle_state();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
